operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter DW, default 8: operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 2: operand-pair FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port clr, input, 1: synchronous flush of FIFO and sequencer.
REQ-006 SHALL have port in_data, input, DW: serial operand byte.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_ready, output, 1: loader accepts in_data.
REQ-009 SHALL have port out_a, output, DW: head-pair operand A (feeds downstream a).
REQ-010 SHALL have port out_b, output, DW: head-pair operand B (feeds downstream b).
REQ-011 SHALL have port out_valid, output, 1: head pair valid.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes head pair.
REQ-013 SHALL have port pair_cnt, output, 8: count of pairs popped.

Function
REQ-014 SHALL transfer an input byte on a cycle with in_valid and in_ready both high; an output pair on a cycle with out_valid and out_ready both high.
REQ-015 SHALL sequence in two states: LOAD_A (transfer writes A holding register, moves to LOAD_B) and LOAD_B (transfer pushes {A, in_data} into FIFO, moves to LOAD_A).
REQ-016 SHALL drive in_ready high in LOAD_A; in LOAD_B, in_ready equals FIFO not full, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid equal to FIFO not empty; out_a/out_b show head entry, 0 when empty.
REQ-018 SHALL give latency of one edge: a B byte transferred at edge k gives out_valid high after edge k when FIFO was empty.
REQ-019 SHALL keep head stable while out_valid high and out_ready low.
REQ-020 SHALL support push and pop on the same edge when not full; occupancy unchanged.
REQ-021 SHALL wrap read/write pointers modulo DEPTH; occupancy counter width log2(DEPTH)+1.
REQ-022 SHALL on clr high: empty FIFO, return to LOAD_A, discard any same-cycle input byte and suppress any same-cycle pop; pair_cnt unchanged.
REQ-023 SHALL increment pair_cnt by one per pop, wrapping 255 to 0.

Reset
REQ-024 SHALL on rst_n low at a rising edge: state LOAD_A, FIFO empty, A register 0, pair_cnt 0; out_valid 0, out_a/out_b 0, in_ready 1 in the following cycle.
REQ-025 SHALL let reset mid-pair discard a captured A; reset has priority over clr.

Configuration
REQ-026 SHALL, with macro OPERAND_LOADER_PAIR_CNT_EN defined, implement pair_cnt per REQ-023.
REQ-027 SHALL, without OPERAND_LOADER_PAIR_CNT_EN, tie pair_cnt to 0 and omit its counter register; all other behaviour is identical.

Structure
REQ-028 SHALL place the state enumeration (LOAD_A, LOAD_B) and default DW/DEPTH constants in shared package operand_loader_pkg.
REQ-029 SHALL implement the FIFO as sub-module pair_fifo (width 2*DW, depth DEPTH, push/pop/full/empty).

Verification
REQ-030 Reset check: hold rst_n low 2 cycles -> out_valid 0, out_a/out_b 0, in_ready 1, pair_cnt 0.
REQ-031 Basic pair: send 0x12 then 0x34, out_ready high -> out_a 0x12, out_b 0x34, out_valid for exactly one cycle, pair_cnt 1.
REQ-032 Back-pressure: out_ready low, send pairs (1,2), (3,4), then A=5 -> A accepted, in_ready 0 in LOAD_B; release out_ready -> pops (1,2), (3,4) in order, then B=6 accepted.
REQ-033 Simultaneous push/pop: 1 entry queued, push and pop same edge -> occupancy stays 1, order preserved.
REQ-034 Flush: after A=0xAA, assert clr with in_valid and 0xBB -> FIFO empty, state LOAD_A, next two bytes 0x01, 0x02 emerge as pair (0x01, 0x02).
REQ-035 Counter wrap (macro defined): pop 256 pairs -> pair_cnt 0; macro undefined -> pair_cnt 0 throughout.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared constants for the operand loader: sequencer state encodings and
// default operand width / pair-FIFO depth.
package operand_loader_pkg;

    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 2;

    localparam logic [0:0] LOAD_A = 1'b0;
    localparam logic [0:0] LOAD_B = 1'b1;

    localparam int PAIR_CNT_W = 8;

endpackage

// File: rtl/operand_loader_pair_fifo.sv
// Purpose: DEPTH-entry FIFO holding packed {A, B} operand pairs.
// Latency: a push is visible at the head after one edge; head reads 0 when empty.
// Backpressure: full blocks pushes upstream; head holds until popped; clr empties it.
module pair_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic do_push;
    logic do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Purpose: assembles serial operand bytes into (A, B) pairs queued for a downstream consumer.
// Latency: one edge from B-byte transfer to out_valid when the queue was empty.
// Backpressure: in_ready drops in LOAD_B while the pair FIFO is full; optional pair_cnt via OPERAND_LOADER_PAIR_CNT_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW-1:0]         out_a,
    output logic [DW-1:0]         out_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAIR_CNT_W-1:0] pair_cnt
);

    logic [0:0]      state;
    logic [DW-1:0]   a_reg;
    logic [2*DW-1:0] head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            in_xfer;
    logic            push;
    logic            pop;

    // in_ready depends only on state and FIFO fullness, never on out_ready.
    assign in_ready  = (state == LOAD_A) ? 1'b1 : !fifo_full;
    assign in_xfer   = in_valid && in_ready && !clr;
    assign push      = in_xfer && (state == LOAD_B);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready && !clr;
    assign out_a     = head[2*DW-1:DW];
    assign out_b     = head[DW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD_A;
            a_reg <= '0;
        end else if (clr) begin
            state <= LOAD_A;
            a_reg <= '0;
        end else if (in_xfer) begin
            if (state == LOAD_A) begin
                a_reg <= in_data;
                state <= LOAD_B;
            end else begin
                state <= LOAD_A;
            end
        end
    end

    pair_fifo #(
        .W     (2 * DW),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data ({a_reg, in_data}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef OPERAND_LOADER_PAIR_CNT_EN
    logic [PAIR_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + PAIR_CNT_W'(1);
        end
    end

    assign pair_cnt = cnt_q;
`else
    assign pair_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: scoreboard of expected pairs plus per-scenario checks.
module tb_operand_loader;

    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          clr       = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          out_valid;
    logic [7:0]    pair_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2*DW-1:0] sb_q[$];
    logic            st_m  = 1'b0;
    logic [DW-1:0]   a_m   = '0;
    logic [7:0]      cnt_m = '0;
    bit              armed = 1'b0;

    operand_loader #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pair_cnt  (pair_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cnt_step(input logic [7:0] c);
`ifdef OPERAND_LOADER_PAIR_CNT_EN
        return c + 8'd1;
`else
        return 8'd0;
`endif
    endfunction

    // Reference model: compares the state left by the last edge, then predicts the next edge.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n) begin
            sb_q.delete();
            st_m  = 1'b0;
            a_m   = '0;
            cnt_m = '0;
            armed = 1'b1;
        end else if (armed) begin
            n_cmp++;
            if (out_valid !== (sb_q.size() != 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %b want %b", out_valid, sb_q.size() != 0);
            end
            exp_rdy = (st_m == 1'b0) || (sb_q.size() < DEPTH);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
            end
            n_cmp++;
            if (pair_cnt !== cnt_m) begin
                n_fail++;
                $display("FAIL pair_cnt: got %0d want %0d", pair_cnt, cnt_m);
            end
            if (sb_q.size() == 0) begin
                n_cmp++;
                if ({out_a, out_b} !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL empty_head: got %h want 0000", {out_a, out_b});
                end
            end
            if (out_valid && out_ready && !clr) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_underflow: got pair %h want none", {out_a, out_b});
                end else begin
                    if ({out_a, out_b} !== sb_q[0]) begin
                        n_fail++;
                        $display("FAIL pop_pair: got %h want %h", {out_a, out_b}, sb_q[0]);
                    end
                    void'(sb_q.pop_front());
                end
                cnt_m = cnt_step(cnt_m);
            end
            if (in_valid && in_ready && !clr) begin
                if (st_m == 1'b0) begin
                    a_m  = in_data;
                    st_m = 1'b1;
                end else begin
                    sb_q.push_back({a_m, in_data});
                    st_m = 1'b0;
                end
            end
            if (clr) begin
                sb_q.delete();
                st_m = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [DW-1:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_timeout: byte %h in_ready %b want 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n         = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: out_valid %b want 0", name, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_a, out_b, in_ready, pair_cnt} !== {1'b0, 8'h00, 8'h00, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL reset: got v=%b a=%h b=%h rdy=%b cnt=%0d want v=0 a=00 b=00 rdy=1 cnt=0",
                     out_valid, out_a, out_b, in_ready, pair_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        logic [7:0] exp_cnt;
        out_ready = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        n_cmp++;
        if ({out_valid, out_a, out_b} !== {1'b1, 8'h12, 8'h34}) begin
            n_fail++;
            $display("FAIL basic_pair: got v=%b a=%h b=%h want v=1 a=12 b=34", out_valid, out_a, out_b);
        end
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        n_cmp++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL basic_valid_cycles: got %0d want 1", n);
        end
        exp_cnt = cnt_step(8'd0);
        n_cmp++;
        if (pair_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL basic_cnt: got %0d want %0d", pair_cnt, exp_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_pair();
        out_ready = 1'b0;
        send_byte(8'h55);
        do_reset();
        send_byte(8'h66);
        send_byte(8'h77);
        n_cmp++;
        if ({out_a, out_b} !== 16'h6677) begin
            n_fail++;
            $display("FAIL reset_mid_pair: got %h want 6677", {out_a, out_b});
        end
        drain("reset_mid_pair");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_byte(8'd1);
        send_byte(8'd2);
        send_byte(8'd3);
        send_byte(8'd4);
        send_byte(8'd5);
        in_data  = 8'd6;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_a, out_b} !== {1'b0, 1'b1, 8'd1, 8'd2}) begin
            n_fail++;
            $display("FAIL backpressure_hold: got rdy=%b v=%b a=%h b=%h want rdy=0 v=1 a=01 b=02",
                     in_ready, out_valid, out_a, out_b);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_byte(8'd6);
        drain("backpressure");
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        send_byte(8'd7);
        send_byte(8'd8);
        send_byte(8'd9);
        out_ready = 1'b1;
        send_byte(8'd10);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, out_a, out_b, in_ready} !== {1'b1, 8'd9, 8'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL simultaneous: got v=%b a=%h b=%h rdy=%b want v=1 a=09 b=0a rdy=1",
                     out_valid, out_a, out_b, in_ready);
        end
        drain("simultaneous");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'hAA);
        in_data  = 8'hBB;
        in_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_state: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        n_cmp++;
        if ({out_valid, out_a, out_b} !== {1'b1, 8'h01, 8'h02}) begin
            n_fail++;
            $display("FAIL flush_pair: got v=%b a=%h b=%h want v=1 a=01 b=02", out_valid, out_a, out_b);
        end
        drain("flush");
    endtask

    task automatic test_counter_wrap();
        logic [7:0] exp_cnt;
        do_reset();
        out_ready = 1'b1;
        exp_cnt   = 8'd0;
        for (int i = 0; i < 255; i++) begin
            send_byte(8'(2 * i));
            send_byte(8'(2 * i + 1));
            exp_cnt = cnt_step(exp_cnt);
        end
        drain("wrap255");
        n_cmp++;
        if (pair_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL cnt_255: got %0d want %0d", pair_cnt, exp_cnt);
        end
        send_byte(8'hF0);
        send_byte(8'hF1);
        drain("wrap256");
        n_cmp++;
        if (pair_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap: got %0d want 0", pair_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_pair();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
